// File: rtl/pkt_header_ingress.sv
// pkt_header_ingress: AXI-Stream ingress that steers header beats into the beat shift register,
// presents the assembled header on a valid/ready port and forwards payload beats.
package pp_package;
  localparam int TDATA_WIDTH = 32;
endpackage

module pkt_header_ingress
  import pp_package::*;
#(
  parameter int HDR_BEATS     = 4,
  parameter int MAX_PKT_BEATS = 256
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           s_axis_tvalid,
  output logic                           s_axis_tready,
  input  logic [TDATA_WIDTH-1:0]         s_axis_tdata,
  input  logic                           s_axis_tlast,
  output logic                           bsr_write_en,
  output logic [TDATA_WIDTH-1:0]         bsr_data,
  input  logic [TDATA_WIDTH*HDR_BEATS-1:0] bsr_data_out,
  output logic                           hdr_valid,
  input  logic                           hdr_ready,
  output logic [TDATA_WIDTH*HDR_BEATS-1:0] hdr_data,
  output logic                           m_axis_tvalid,
  input  logic                           m_axis_tready,
  output logic [TDATA_WIDTH-1:0]         m_axis_tdata,
  output logic                           m_axis_tlast,
  output logic                           err_runt,
  output logic                           err_long
);
  localparam int HW = $clog2(HDR_BEATS);
  localparam int PW = $clog2(MAX_PKT_BEATS + 1);
  localparam logic [HW-1:0] HDR_LAST = HW'(HDR_BEATS - 1);
  localparam logic [PW-1:0] MAX_C = PW'(MAX_PKT_BEATS);
  typedef enum logic [2:0] {HDR, PAD, HOLD, PAYLOAD, DROP} state_t;
  state_t state;
  logic [HW-1:0] hdr_cnt, pad_cnt;
  logic [PW-1:0] pkt_cnt, pkt_nxt;
  logic hdr_only, accept, at_max;
  always_comb begin
    s_axis_tready = rst && (state == HDR || state == DROP || (state == PAYLOAD && m_axis_tready));
    accept        = s_axis_tvalid && s_axis_tready;
    pkt_nxt       = pkt_cnt + 1'b1;
    at_max        = pkt_nxt == MAX_C;
    m_axis_tvalid = state == PAYLOAD && s_axis_tvalid;
    m_axis_tdata  = s_axis_tdata;
    m_axis_tlast  = s_axis_tlast || (state == PAYLOAD && at_max);
    bsr_write_en  = (state == HDR && accept) || state == PAD;
    bsr_data      = state == PAD ? '0 : s_axis_tdata;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= HDR;
      hdr_cnt   <= '0;
      pad_cnt   <= '0;
      pkt_cnt   <= '0;
      hdr_only  <= 1'b0;
      hdr_valid <= 1'b0;
      hdr_data  <= '0;
      err_runt  <= 1'b0;
      err_long  <= 1'b0;
    end else begin
      err_runt <= 1'b0;
      err_long <= 1'b0;
      case (state)
        HDR: if (accept) begin
          pkt_cnt <= pkt_nxt;
          if (hdr_cnt == HDR_LAST) begin
            hdr_data  <= bsr_data_out;
            hdr_valid <= 1'b1;
            hdr_cnt   <= '0;
            hdr_only  <= s_axis_tlast;
            state     <= HOLD;
          end else if (s_axis_tlast) begin
            err_runt <= 1'b1;
            pad_cnt  <= HDR_LAST - hdr_cnt;
            state    <= PAD;
          end else begin
            hdr_cnt <= hdr_cnt + 1'b1;
          end
        end
        // zero-fill until the shift register pointer wraps back to slot 0
        PAD: begin
          pad_cnt <= pad_cnt - 1'b1;
          if (pad_cnt == HW'(1)) begin
            hdr_cnt <= '0;
            pkt_cnt <= '0;
            state   <= HDR;
          end
        end
        HOLD: if (hdr_ready) begin
          hdr_valid <= 1'b0;
          if (hdr_only) begin
            pkt_cnt <= '0;
            state   <= HDR;
          end else begin
            state <= PAYLOAD;
          end
        end
        PAYLOAD: if (accept) begin
          pkt_cnt <= pkt_nxt;
          if (s_axis_tlast) begin
            pkt_cnt <= '0;
            state   <= HDR;
          end else if (at_max) begin
            err_long <= 1'b1;
            state    <= DROP;
          end
        end
        DROP: if (accept && s_axis_tlast) begin
          pkt_cnt <= '0;
          state   <= HDR;
        end
        default: state <= HDR;
      endcase
    end
  end
endmodule

// File: tb/tb_pkt_header_ingress.sv
// tb_pkt_header_ingress: directed bench with a beat shift register model and handshake monitors.
module tb_pkt_header_ingress;
  localparam int W = 32;
  localparam int HB = 4;
  localparam int MAXB = 8;
  logic clk = 0, rst = 0;
  logic s_tvalid = 0, s_tlast = 0, hdr_ready = 0, m_ready = 1;
  logic [W-1:0] s_tdata = '0;
  logic s_tready, bsr_we, hdr_valid, m_tvalid, m_tlast, err_runt, err_long;
  logic [W-1:0] bsr_data, m_tdata;
  logic [W*HB-1:0] bsr_out, hdr_data;
  int checks = 0, failures = 0;
  logic [W-1:0] mem [HB];
  int ptr;
  logic [W-1:0] wr_q[$];
  logic [W:0] m_q[$];
  logic [W*HB-1:0] h_q[$];
  int hv_cycles, runt_n, long_n;
  logic tog_en = 0;

  pkt_header_ingress #(.HDR_BEATS(HB), .MAX_PKT_BEATS(MAXB)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tdata(s_tdata), .s_axis_tlast(s_tlast),
    .bsr_write_en(bsr_we), .bsr_data(bsr_data), .bsr_data_out(bsr_out),
    .hdr_valid(hdr_valid), .hdr_ready(hdr_ready), .hdr_data(hdr_data),
    .m_axis_tvalid(m_tvalid), .m_axis_tready(m_ready), .m_axis_tdata(m_tdata), .m_axis_tlast(m_tlast),
    .err_runt(err_runt), .err_long(err_long)
  );

  always #5 clk = ~clk;

  // shift register model: circular write pointer, current write bypassed onto data_out
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= 0;
      for (int i = 0; i < HB; i++) mem[i] <= '0;
    end else if (bsr_we) begin
      mem[ptr] <= bsr_data;
      ptr <= (ptr + 1) % HB;
    end
  end
  always_comb begin
    bsr_out = '0;
    for (int i = 0; i < HB; i++)
      bsr_out[i*W +: W] = (bsr_we && ptr == i) ? bsr_data : mem[i];
  end

  always @(negedge clk) begin
    if (bsr_we) wr_q.push_back(bsr_data);
    if (m_tvalid && m_ready) m_q.push_back({m_tlast, m_tdata});
    if (hdr_valid) hv_cycles++;
    if (hdr_valid && hdr_ready) h_q.push_back(hdr_data);
    if (err_runt) runt_n++;
    if (err_long) long_n++;
  end

  always @(posedge clk) begin
    #1;
    if (tog_en) m_ready = 1'($urandom_range(0, 1));
  end

  function automatic logic [W*HB-1:0] hdr4(input int a, input int b, input int c, input int d);
    return {W'(d), W'(c), W'(b), W'(a)};
  endfunction

  task automatic clear_mon();
    wr_q.delete(); m_q.delete(); h_q.delete();
    hv_cycles = 0; runt_n = 0; long_n = 0;
  endtask

  task automatic drive_beat(input int d, input logic l);
    int t = 0;
    s_tvalid = 1; s_tdata = W'(d); s_tlast = l;
    do begin @(negedge clk); t++; end while (!s_tready && t < 200);
    if (!s_tready) begin
      checks++; failures++;
      $display("FAIL beat_timeout data=%0d got no tready required tready", d);
    end
    @(posedge clk); #1;
    s_tvalid = 0; s_tlast = 0;
  endtask

  task automatic send_pkt(input int first, input int n);
    for (int i = 0; i < n; i++) drive_beat(first + i, i == n - 1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_m(input string name, input int first, input int n, input int last_at);
    checks++;
    if (m_q.size() != n) begin
      failures++;
      $display("FAIL %s_count got=%0d required=%0d", name, m_q.size(), n);
    end else begin
      for (int i = 0; i < n; i++) begin
        checks++;
        if (m_q[i] !== {1'(i == last_at), W'(first + i)}) begin
          failures++;
          $display("FAIL %s_beat%0d got=%h required=%h", name, i, m_q[i], {1'(i == last_at), W'(first + i)});
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 0;
    idle(2);
    @(negedge clk);
    checks++;
    if ({s_tready, hdr_valid, m_tvalid, bsr_we, err_runt, err_long} !== 6'b0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b required=000000", {s_tready, hdr_valid, m_tvalid, bsr_we, err_runt, err_long});
    end
    checks++;
    if (hdr_data !== '0) begin
      failures++;
      $display("FAIL reset_hdr got=%h required=0", hdr_data);
    end
    @(posedge clk); #1;
    rst = 1;
    idle(1);
  endtask

  task automatic test_basic();
    clear_mon();
    hdr_ready = 1; m_ready = 1;
    send_pkt(1, 7);
    idle(4);
    checks++;
    if (wr_q.size() != 4 || wr_q[0] !== 1 || wr_q[3] !== 4) begin
      failures++;
      $display("FAIL basic_writes got_n=%0d required_n=4 (1..4)", wr_q.size());
    end
    checks++;
    if (h_q.size() != 1 || h_q[0] !== hdr4(1, 2, 3, 4)) begin
      failures++;
      $display("FAIL basic_hdr got=%h required=%h", h_q.size() ? h_q[0] : '0, hdr4(1, 2, 3, 4));
    end
    checks++;
    if (hv_cycles != 1) begin
      failures++;
      $display("FAIL basic_hv_cycles got=%0d required=1", hv_cycles);
    end
    check_m("basic", 5, 3, 2);
  endtask

  task automatic test_hold();
    clear_mon();
    hdr_ready = 0;
    fork
      send_pkt(1, 6);
      begin
        int t = 0;
        logic ok = 1;
        do begin @(negedge clk); t++; end while (!hdr_valid && t < 50);
        for (int i = 0; i < 5; i++) begin
          if (i > 0) @(negedge clk);
          if (!hdr_valid || s_tready || hdr_data !== hdr4(1, 2, 3, 4)) ok = 0;
        end
        checks++;
        if (!ok) begin
          failures++;
          $display("FAIL hold_stable got valid=%b tready=%b hdr=%h required valid=1 tready=0 hdr=%h", hdr_valid, s_tready, hdr_data, hdr4(1, 2, 3, 4));
        end
        @(posedge clk); #1;
        hdr_ready = 1;
        @(negedge clk);
        @(posedge clk); #1;
        hdr_ready = 0;
        @(negedge clk);
        checks++;
        if (!(m_tvalid && s_tready && m_tdata == 5)) begin
          failures++;
          $display("FAIL hold_first_payload got tvalid=%b tready=%b data=%0d required 1 1 5", m_tvalid, s_tready, m_tdata);
        end
      end
    join
    idle(3);
    check_m("hold", 5, 2, 1);
    hdr_ready = 1;
  endtask

  task automatic test_runt();
    clear_mon();
    send_pkt(10, 2);
    send_pkt(1, 5);
    idle(4);
    checks++;
    if (runt_n != 1) begin
      failures++;
      $display("FAIL runt_pulse got=%0d required=1", runt_n);
    end
    checks++;
    if (wr_q.size() != 8 || wr_q[2] !== 0 || wr_q[3] !== 0 || wr_q[4] !== 1) begin
      failures++;
      $display("FAIL runt_pad_writes got_n=%0d required_n=8 with two zero pads", wr_q.size());
    end
    checks++;
    if (h_q.size() != 1 || h_q[0] !== hdr4(1, 2, 3, 4)) begin
      failures++;
      $display("FAIL runt_next_hdr got_n=%0d hdr=%h required=%h", h_q.size(), h_q.size() ? h_q[0] : '0, hdr4(1, 2, 3, 4));
    end
    check_m("runt", 5, 1, 0);
  endtask

  task automatic test_hdr_only();
    clear_mon();
    send_pkt(1, 4);
    drive_beat(9, 0); drive_beat(8, 0); drive_beat(7, 0); drive_beat(6, 0); drive_beat(5, 1);
    idle(4);
    checks++;
    if (h_q.size() != 2 || h_q[0] !== hdr4(1, 2, 3, 4) || h_q[1] !== hdr4(9, 8, 7, 6)) begin
      failures++;
      $display("FAIL hdr_only_headers got_n=%0d required 2 headers", h_q.size());
    end
    check_m("hdr_only", 5, 1, 0);
  endtask

  task automatic test_long();
    clear_mon();
    send_pkt(1, 12);
    send_pkt(1, 5);
    idle(4);
    checks++;
    if (long_n != 1) begin
      failures++;
      $display("FAIL long_pulse got=%0d required=1", long_n);
    end
    checks++;
    if (h_q.size() != 2 || h_q[1] !== hdr4(1, 2, 3, 4)) begin
      failures++;
      $display("FAIL long_next_hdr got_n=%0d required=2", h_q.size());
    end
    checks++;
    if (m_q.size() != 5 || m_q[3] !== {1'b1, W'(8)} || m_q[4] !== {1'b1, W'(5)}) begin
      failures++;
      $display("FAIL long_payload got_n=%0d required=5 with forced tlast on 8", m_q.size());
    end
  endtask

  task automatic test_back_to_back();
    clear_mon();
    tog_en = 1;
    send_pkt(21, 8);
    send_pkt(31, 6);
    idle(3);
    tog_en = 0;
    m_ready = 1;
    checks++;
    if (long_n != 0) begin
      failures++;
      $display("FAIL b2b_max_len_err got=%0d required=0", long_n);
    end
    checks++;
    if (m_q.size() != 6 || m_q[0] !== {1'b0, W'(25)} || m_q[3] !== {1'b1, W'(28)} ||
        m_q[4] !== {1'b0, W'(35)} || m_q[5] !== {1'b1, W'(36)}) begin
      failures++;
      $display("FAIL b2b_payload got_n=%0d required=6 (25..28,35,36)", m_q.size());
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 1; i <= 6; i++) drive_beat(i, 0);
    rst = 0;
    @(negedge clk);
    checks++;
    if ({s_tready, hdr_valid, m_tvalid, bsr_we, err_runt, err_long} !== 6'b0 || hdr_data !== '0) begin
      failures++;
      $display("FAIL reset_mid_outputs got=%b hdr=%h required=000000 hdr=0",
               {s_tready, hdr_valid, m_tvalid, bsr_we, err_runt, err_long}, hdr_data);
    end
    @(posedge clk); #1;
    rst = 1;
    clear_mon();
    send_pkt(11, 5);
    idle(4);
    checks++;
    if (h_q.size() != 1 || h_q[0] !== hdr4(11, 12, 13, 14)) begin
      failures++;
      $display("FAIL reset_mid_hdr got_n=%0d hdr=%h required=%h", h_q.size(), h_q.size() ? h_q[0] : '0, hdr4(11, 12, 13, 14));
    end
    check_m("reset_mid", 15, 1, 0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_runt();
    test_hdr_only();
    test_long();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running required=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/pkt_header_ingress.md
Name: pkt_header_ingress

Overview:
- AXI-Stream ingress controller of the packet parser.
- Accepts input packets and steers the first HDR_BEATS beats into the downstream beat shift register (write_en/data_in).
- Registers the assembled header from that register's data_out and presents it on a valid/ready header port.
- Forwards the remaining payload beats on an AXI-Stream master. Flags runt and overlong packets, and re-aligns the shift register's write pointer after a runt.

Parameters:
- HDR_BEATS, 4: header length in beats. Must equal the shift register DEPTH.
- MAX_PKT_BEATS, 256: maximum total beats per packet, header included. Must be greater than HDR_BEATS.
- TDATA_WIDTH: pp_package constant, not overridable here.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-low
- s_axis_tvalid  in  1  input beat valid
- s_axis_tready  out  1  input beat ready
- s_axis_tdata  in  TDATA_WIDTH  input beat data
- s_axis_tlast  in  1  input last beat of packet
- bsr_write_en  out  1  shift register write enable
- bsr_data  out  TDATA_WIDTH  shift register write data
- bsr_data_out  in  TDATA_WIDTH*HDR_BEATS  shift register contents, with bypass of the current write
- hdr_valid  out  1  header available
- hdr_ready  in  1  header consumer ready
- hdr_data  out  TDATA_WIDTH*HDR_BEATS  registered header; beat k in bits [(k+1)*TDATA_WIDTH-1 : k*TDATA_WIDTH]
- m_axis_tvalid  out  1  payload valid
- m_axis_tready  in  1  payload ready
- m_axis_tdata  out  TDATA_WIDTH  payload data
- m_axis_tlast  out  1  payload last
- err_runt  out  1  one-cycle pulse: packet ended before the header was complete
- err_long  out  1  one-cycle pulse: packet exceeded MAX_PKT_BEATS

Behaviour:
- Counters:
  - hdr_cnt, width $clog2(HDR_BEATS).
  - pkt_cnt, width $clog2(MAX_PKT_BEATS+1).
  - "Accept" means s_axis_tvalid && s_axis_tready.
- Reset (rst low, asynchronous):
  - State = HDR; hdr_cnt = 0; pkt_cnt = 0.
  - hdr_valid = 0, hdr_data = 0, err_runt = 0, err_long = 0.
  - s_axis_tready = 0, m_axis_tvalid = 0, bsr_write_en = 0.
  - Reset mid-packet discards all state. The shift register is reset by the same rst, so the two stay aligned.
- HDR state:
  - s_axis_tready = 1, m_axis_tvalid = 0.
  - bsr_write_en = accept (combinational); bsr_data = s_axis_tdata.
  - Each accept increments hdr_cnt and pkt_cnt.
  - Accept with hdr_cnt == HDR_BEATS-1: register hdr_data <= bsr_data_out in the same edge (the bypass supplies the current beat). Set hdr_valid = 1 from the next cycle. Clear hdr_cnt. Record hdr_only = s_axis_tlast. Go to HOLD.
  - Accept with s_axis_tlast and hdr_cnt < HDR_BEATS-1 (runt): pulse err_runt next cycle. pad_cnt = HDR_BEATS-1-hdr_cnt. Go to PAD. No hdr_valid.
- PAD state:
  - s_axis_tready = 0.
  - bsr_write_en = 1, bsr_data = 0, every cycle for pad_cnt cycles. This returns the shift register pointer to 0.
  - Then clear hdr_cnt and pkt_cnt and go to HDR.
- HOLD state:
  - s_axis_tready = 0; hdr_valid held and hdr_data stable until hdr_ready.
  - On the handshake: hdr_valid = 0 next cycle.
    - hdr_only: clear pkt_cnt, go to HDR.
    - otherwise: go to PAYLOAD.
  - The first payload beat may be accepted in the cycle after the handshake.
- PAYLOAD state (combinational pass-through, no added latency):
  - m_axis_tvalid = s_axis_tvalid; s_axis_tready = m_axis_tready.
  - m_axis_tdata = s_axis_tdata; m_axis_tlast = s_axis_tlast.
  - pkt_cnt increments per accepted beat.
  - Accept with s_axis_tlast: clear pkt_cnt, go to HDR.
  - Accept without tlast where pkt_cnt+1 == MAX_PKT_BEATS:
    - Force m_axis_tlast = 1 on that beat.
    - Pulse err_long next cycle; go to DROP.
  - A tlast on exactly beat MAX_PKT_BEATS is legal: no error.
- DROP state:
  - s_axis_tready = 1, m_axis_tvalid = 0.
  - Beats are discarded until an accept with tlast. Then clear pkt_cnt and go to HDR.
- Invariants:
  - No input beat is accepted in HOLD or PAD.
  - bsr_write_en is never asserted outside HDR/PAD.
  - m_axis_tvalid is 0 outside PAYLOAD.

Test Plan:
- HDR_BEATS=4; packet of beats 1..7 (tlast on 7); hdr_ready=1 -> bsr_write_en on beats 1-4; hdr_data = {4,3,2,1}; hdr_valid high exactly one cycle; m_axis carries 5,6,7 with tlast on 7.
- hdr_ready low for 5 cycles after hdr_valid -> s_axis_tready = 0 and hdr_data stable for those 5 cycles; payload starts the cycle after the handshake.
- Runt packet A,B (tlast on B), then packet 1..5 -> err_runt pulses once; exactly 2 PAD writes of 0; the next hdr_data = {4,3,2,1}; no hdr_valid for the runt.
- Header-only packet 1..4 (tlast on 4) -> hdr_valid, no m_axis_tvalid; the next packet is parsed as a new header.
- MAX_PKT_BEATS=8, 12-beat packet -> m_axis beats 5-8 with forced tlast on 8; err_long pulses once; beats 9-12 accepted and dropped; the following packet parses normally.
- m_axis_tready toggling randomly mid-payload -> no lost or duplicated beats. Assert rst mid-payload, then release -> all outputs at reset values; the next packet's header is correct.
